// File: rtl/maq_h.sv
// maq_h: hours stage of the clock. Counts 00-23 in BCD on each carry pulse from the
// minutes stage, flags the day carry on the 23->00 roll, offers a button-driven set
// mode and decodes the count for a 12 h or 24 h display.
//
// Ports:
//   clk             system clock, rising edge
//   rst             asynchronous active-low reset
//   incrementa_hora one-cycle carry from the minutes stage
//   modo_12h        display format: 0 = 24 h, 1 = 12 h (display only)
//   ajuste_en       asynchronous level, 1 requests set mode
//   ajuste_btn      asynchronous push-button, each press steps the hour in set mode
//   bcd_h_lsd       displayed hour, units digit
//   bcd_h_msd       displayed hour, tens digit
//   pm              1 when the internal hour is 12-23
//   em_ajuste       1 while in set mode
//   incrementa_dia  combinational day carry
module maq_h #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       incrementa_hora,
  input  logic       modo_12h,
  input  logic       ajuste_en,
  input  logic       ajuste_btn,
  output logic [3:0] bcd_h_lsd,
  output logic [1:0] bcd_h_msd,
  output logic       pm,
  output logic       em_ajuste,
  output logic       incrementa_dia
);

  typedef enum logic [0:0] {StRun, StSet} state_e;

  state_e                 state_q, state_d;
  logic [3:0]             h_lsd_q, h_lsd_d;
  logic [1:0]             h_msd_q, h_msd_d;
  logic [SYNC_STAGES-1:0] en_sync_q, en_sync_d;
  logic [SYNC_STAGES-1:0] btn_sync_q, btn_sync_d;
  logic                   btn_prev_q, btn_prev_d;

  logic en_s, btn_s, passo, step, is_23;

  assign en_s  = en_sync_q[SYNC_STAGES-1];
  assign btn_s = btn_sync_q[SYNC_STAGES-1];
  // btn_prev resets to 0 together with the synchroniser, so a button held through
  // reset yields a passo only while still in RUN, where it is ignored.
  assign passo = btn_s & ~btn_prev_q;
  assign is_23 = (h_msd_q == 2'd2) && (h_lsd_q == 4'd3);

  // Both the count update and the transition use the current state.
  assign step = (state_q == StRun) ? incrementa_hora : passo;

  always_comb begin
    en_sync_d  = {en_sync_q[SYNC_STAGES-2:0], ajuste_en};
    btn_sync_d = {btn_sync_q[SYNC_STAGES-2:0], ajuste_btn};
    btn_prev_d = btn_s;

    h_lsd_d = h_lsd_q;
    h_msd_d = h_msd_q;
    if (step) begin
      if (is_23) begin
        h_lsd_d = 4'd0;
        h_msd_d = 2'd0;
      end else if (h_lsd_q == 4'd9) begin
        h_lsd_d = 4'd0;
        h_msd_d = h_msd_q + 2'd1;
      end else begin
        h_lsd_d = h_lsd_q + 4'd1;
      end
    end

    state_d = state_q;
    unique case (state_q)
      StRun: if (en_s)  state_d = StSet;
      StSet: if (!en_s) state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StRun;
      h_lsd_q    <= 4'd0;
      h_msd_q    <= 2'd0;
      en_sync_q  <= '0;
      btn_sync_q <= '0;
      btn_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      h_lsd_q    <= h_lsd_d;
      h_msd_q    <= h_msd_d;
      en_sync_q  <= en_sync_d;
      btn_sync_q <= btn_sync_d;
      btn_prev_q <= btn_prev_d;
    end
  end

  assign em_ajuste      = (state_q == StSet);
  assign incrementa_dia = (state_q == StRun) & incrementa_hora & is_23;

  // Display decode through a small binary hour value.
  logic [4:0] hour_bin, disp_bin, tens_bin;

  always_comb begin
    hour_bin = ({3'b000, h_msd_q} * 5'd10) + {1'b0, h_lsd_q};
    pm       = (hour_bin >= 5'd12);

    disp_bin = hour_bin;
    if (modo_12h) begin
      if (hour_bin == 5'd0) begin
        disp_bin = 5'd12;
      end else if (hour_bin > 5'd12) begin
        disp_bin = hour_bin - 5'd12;
      end
    end

    if (disp_bin >= 5'd20) begin
      bcd_h_msd = 2'd2;
      tens_bin  = 5'd20;
    end else if (disp_bin >= 5'd10) begin
      bcd_h_msd = 2'd1;
      tens_bin  = 5'd10;
    end else begin
      bcd_h_msd = 2'd0;
      tens_bin  = 5'd0;
    end
    bcd_h_lsd = 4'(disp_bin - tens_bin);
  end

endmodule
